// File: rtl/pipe_stall_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// pipe_stall_ctrl_pkg
//   Shared definitions for the pipeline stall/flush controller: stage bus
//   width and bit indices, controller state encoding, the fixed Stall/Flush
//   response patterns and a saturating 32-bit increment helper.
//   Stage bus bit order is {MEM_WB, EX_MEM, ID_EX, IF_ID, PC}; bit 0 is PC.
// ---------------------------------------------------------------------------
package pipe_stall_ctrl_pkg;

    localparam int STAGE_W    = 5;
    localparam int STG_PC     = 0;
    localparam int STG_IF_ID  = 1;
    localparam int STG_ID_EX  = 2;
    localparam int STG_EX_MEM = 3;
    localparam int STG_MEM_WB = 4;

    typedef logic [STAGE_W-1:0] stage_bus_t;

    typedef enum logic [1:0] {
        CTRL_RUN      = 2'd0,
        CTRL_MEM_WAIT = 2'd1,
        CTRL_ERROR    = 2'd2
    } ctrl_state_e;

    // Memory wait: everything upstream of WB holds, WB gets a bubble so the
    // instruction already retired is not written twice.
    localparam stage_bus_t STALL_MEM  = 5'b01111;
    localparam stage_bus_t FLUSH_MEM  = 5'b10000;
    // Load-use: hold PC and IF/ID, inject one bubble into EX.
    localparam stage_bus_t STALL_LU   = 5'b00011;
    localparam stage_bus_t FLUSH_LU   = 5'b00100;
    // Taken branch: squash the wrong-path fetch sitting in IF/ID.
    localparam stage_bus_t FLUSH_BR   = 5'b00010;
    // Error: freeze the whole pipeline.
    localparam stage_bus_t STALL_ALL  = 5'b11111;

    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/pipe_stall_ctrl_hazard.sv
// ---------------------------------------------------------------------------
// pipe_stall_ctrl_hazard
//   Combinational load-use hazard detector. Flags when the instruction in EX
//   is a load to a non-zero register that the instruction in ID reads.
// Ports:
//   ID_Rs_Addr, ID_Rt_Addr   in  source register fields of the ID instruction
//   ID_Uses_Rs, ID_Uses_Rt   in  ID instruction actually reads rs / rt
//   EX_Mem2R                 in  EX instruction is a load
//   EX_Reg_WriteEn           in  EX instruction writes a register
//   EX_Reg_WriteAddr         in  EX destination register
//   load_use_o               out hazard present this cycle
// ---------------------------------------------------------------------------
module pipe_stall_ctrl_hazard (
    input  logic [4:0] ID_Rs_Addr,
    input  logic [4:0] ID_Rt_Addr,
    input  logic       ID_Uses_Rs,
    input  logic       ID_Uses_Rt,
    input  logic       EX_Mem2R,
    input  logic       EX_Reg_WriteEn,
    input  logic [4:0] EX_Reg_WriteAddr,
    output logic       load_use_o
);

    logic rs_hit, rt_hit;

    assign rs_hit = ID_Uses_Rs && (ID_Rs_Addr == EX_Reg_WriteAddr);
    assign rt_hit = ID_Uses_Rt && (ID_Rt_Addr == EX_Reg_WriteAddr);

    // $0 is hardwired zero, so a "load" to it never creates a dependency.
    assign load_use_o = EX_Mem2R && EX_Reg_WriteEn && (EX_Reg_WriteAddr != 5'd0)
                        && (rs_hit || rt_hit);

endmodule

// File: rtl/pipe_stall_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_stall_ctrl
//   Central stall/flush controller for a 5-stage pipeline. Resolves, in
//   priority order, a frozen error state, data-memory waits, load-use
//   hazards and taken branches into per-register hold (Stall) and bubble
//   (Flush) controls. A wait counter bounds consecutive Mem_Busy cycles and
//   traps into a sticky ERROR state when the bound is exceeded.
// Parameters:
//   MEM_TIMEOUT   max consecutive busy cycles tolerated in MEM_WAIT; 0 = off
// Ports:
//   clk, rst            clock; asynchronous active-low reset
//   ID_*                ID-stage source register info
//   EX_*                EX-stage load/writeback info
//   ID_Branch_Taken     branch resolved taken in ID
//   Mem_Busy            data memory not ready for the MEM-stage access
//   Stall, Flush        {MEM_WB,EX_MEM,ID_EX,IF_ID,PC} hold / bubble enables
//   Ctrl_State          0 RUN, 1 MEM_WAIT, 2 ERROR
//   Mem_Timeout         sticky timeout flag
//   Stall_Count         (PIPE_STALL_CTRL_PERF_EN only) saturating count of
//                       cycles with the PC held
// Configuration macro: PIPE_STALL_CTRL_PERF_EN
// ---------------------------------------------------------------------------
module pipe_stall_ctrl
    import pipe_stall_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  ID_Rs_Addr,
    input  logic [4:0]  ID_Rt_Addr,
    input  logic        ID_Uses_Rs,
    input  logic        ID_Uses_Rt,
    input  logic        EX_Mem2R,
    input  logic        EX_Reg_WriteEn,
    input  logic [4:0]  EX_Reg_WriteAddr,
    input  logic        ID_Branch_Taken,
    input  logic        Mem_Busy,
    output logic [4:0]  Stall,
    output logic [4:0]  Flush,
    output logic [1:0]  Ctrl_State,
    output logic        Mem_Timeout
`ifdef PIPE_STALL_CTRL_PERF_EN
    ,
    output logic [31:0] Stall_Count
`endif
);

    localparam int CNT_W = (MEM_TIMEOUT <= 0) ? 1 : $clog2(MEM_TIMEOUT + 1);
    localparam bit TIMEOUT_EN = (MEM_TIMEOUT != 0);
    localparam logic [CNT_W-1:0] TO_VAL  = CNT_W'(MEM_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    ctrl_state_e      state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             timeout_q;
    logic             load_use;

    pipe_stall_ctrl_hazard u_hazard (
        .ID_Rs_Addr       (ID_Rs_Addr),
        .ID_Rt_Addr       (ID_Rt_Addr),
        .ID_Uses_Rs       (ID_Uses_Rs),
        .ID_Uses_Rt       (ID_Uses_Rt),
        .EX_Mem2R         (EX_Mem2R),
        .EX_Reg_WriteEn   (EX_Reg_WriteEn),
        .EX_Reg_WriteAddr (EX_Reg_WriteAddr),
        .load_use_o       (load_use)
    );

    // Controller FSM with wait counter and sticky timeout flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= CTRL_RUN;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            case (state_q)
                CTRL_RUN: begin
                    if (Mem_Busy) begin
                        state_q <= CTRL_MEM_WAIT;
                        cnt_q   <= CNT_W'(1);
                    end
                end
                CTRL_MEM_WAIT: begin
                    if (!Mem_Busy) begin
                        state_q <= CTRL_RUN;
                        cnt_q   <= '0;
                    end else if (TIMEOUT_EN && (cnt_q == TO_VAL)) begin
                        state_q   <= CTRL_ERROR;
                        timeout_q <= 1'b1;
                    end else if (cnt_q != CNT_MAX) begin
                        // Saturate rather than wrap when the timeout is off.
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                CTRL_ERROR: ;  // left only through reset
                default: begin
                    state_q <= CTRL_RUN;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    // Stall/Flush follow Mem_Busy combinationally so the stall ends in the
    // same cycle memory becomes ready. A branch is ignored while IF/ID is
    // held; the held instruction re-raises it once the hold clears.
    always_comb begin
        Stall = '0;
        Flush = '0;
        if (state_q == CTRL_ERROR) begin
            Stall = STALL_ALL;
        end else if (Mem_Busy) begin
            Stall = STALL_MEM;
            Flush = FLUSH_MEM;
        end else if (load_use) begin
            Stall = STALL_LU;
            Flush = FLUSH_LU;
        end else if (ID_Branch_Taken) begin
            Flush = FLUSH_BR;
        end
    end

    assign Ctrl_State  = state_q;
    assign Mem_Timeout = timeout_q;

`ifdef PIPE_STALL_CTRL_PERF_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    assign stall_cnt_d = Stall[STG_PC] ? sat_inc32(stall_cnt_q) : stall_cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) stall_cnt_q <= '0;
        else      stall_cnt_q <= stall_cnt_d;
    end

    assign Stall_Count = stall_cnt_q;
`endif

endmodule
